pipeline_if: RTL and testbench

// Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
// - Owns the PC register and selects the next PC from the decode-stage redirect request.
// - Drives the instruction-memory address and captures the fetched word into the IF/ID register.
// - Handles load-use stall (hold) and redirect flush (bubble insertion).
// - PC[31] is the kernel-mode bit; it is carried through IF/ID to decode.

---
 rtl/pipeline_defs.sv | 24 ++
 rtl/pipeline_if_pc_next_sel.sv | 58 +++++
 rtl/pipeline_if.sv | 78 +++++++
 tb/tb_pipeline_if.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// vector addresses and the kernel-bit-preserving sequential increment.
package pipeline_defs;

    typedef enum logic [2:0] {
        PC_SEQ   = 3'd0,
        PC_BR    = 3'd1,
        PC_J     = 3'd2,
        PC_JR    = 3'd3,
        PC_ILLOP = 3'd4,
        PC_XADR  = 3'd5
    } pcsrc_e;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_PC  = 32'h8000_0008;

    // Bit 31 is the kernel-mode flag; the +4 carry must never reach it.
    function automatic logic [31:0] seq_pc(input logic [31:0] x);
        return {x[31], x[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pipeline_if_pc_next_sel.sv
// Combinational next-PC / flush selection for the fetch stage. Stall has
// priority over every redirect; redirects are prioritised exception first.
module pc_next_sel
    import pipeline_defs::*;
#(
    parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
    parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
    input  logic [31:0] pc_i,
    input  logic [3:0]  id_pc_hi_i,
    input  logic        stall_i,
    input  logic [2:0]  pcsrc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] conba_i,
    input  logic [25:0] jt_i,
    input  logic [29:0] jr_word_i,
    output logic [31:0] pc_d_o,
    output logic        flush_o,
    output logic        hold_o
);

    always_comb begin
        pc_d_o  = seq_pc(pc_i);
        flush_o = 1'b0;
        hold_o  = 1'b0;
        if (stall_i) begin
            pc_d_o = pc_i;
            hold_o = 1'b1;
        end else begin
            case (pcsrc_i)
                PC_XADR: begin
                    pc_d_o  = XADR_PC;
                    flush_o = 1'b1;
                end
                PC_ILLOP: begin
                    pc_d_o  = ILLOP_PC;
                    flush_o = 1'b1;
                end
                PC_JR: begin
                    pc_d_o  = {jr_word_i, 2'b00};
                    flush_o = 1'b1;
                end
                PC_J: begin
                    pc_d_o  = {id_pc_hi_i, jt_i, 2'b00};
                    flush_o = 1'b1;
                end
                PC_BR: begin
                    if (branch_taken_i) begin
                        pc_d_o  = conba_i;
                        flush_o = 1'b1;
                    end
                end
                default: ;  // PC_SEQ and reserved codes fall through sequentially
            endcase
        end
    end

endmodule

// File: rtl/pipeline_if.sv
// MIPS instruction-fetch stage: PC register and IF/ID register, with
// load-use hold and single-bubble redirect flush.
module pipeline_if
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
    parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  PCSrc,
    input  logic        branch_taken,
    input  logic [31:0] ConBA,
    input  logic [25:0] JT,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instruction,
    output logic        IF_flush
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        flush, hold;

    pc_next_sel #(
        .ILLOP_PC(ILLOP_PC),
        .XADR_PC (XADR_PC)
    ) u_sel (
        .pc_i          (pc_q),
        .id_pc_hi_i    (id_pc_q[31:28]),
        .stall_i       (stall),
        .pcsrc_i       (PCSrc),
        .branch_taken_i(branch_taken),
        .conba_i       (ConBA),
        .jt_i          (JT),
        .jr_word_i     (jr_target[31:2]),
        .pc_d_o        (pc_d),
        .flush_o       (flush),
        .hold_o        (hold)
    );

    // A bubble carries the target's sequential PC so an interrupt taken on it returns to the target.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (!hold) begin
            id_pc_d    = seq_pc(pc_d);
            id_instr_d = NOP_WORD;
            if (!flush) begin
                id_pc_d    = pc_d;
                id_instr_d = imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= seq_pc(RESET_PC);
            id_instr_q <= NOP_WORD;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign imem_addr      = pc_q;
    assign ID_PC          = id_pc_q;
    assign ID_instruction = id_instr_q;
    assign IF_flush       = flush;

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for the fetch stage; imem returns ~addr so fetched words are nonzero and address-unique.
module tb_pipeline_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  PCSrc;
    logic        branch_taken;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic [31:0] jr_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] ID_PC;
    logic [31:0] ID_instruction;
    logic        IF_flush;

    int checks   = 0;
    int failures = 0;

    pipeline_if dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .PCSrc         (PCSrc),
        .branch_taken  (branch_taken),
        .ConBA         (ConBA),
        .JT            (JT),
        .jr_target     (jr_target),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .ID_PC         (ID_PC),
        .ID_instruction(ID_instruction),
        .IF_flush      (IF_flush)
    );

    always #5 clk = ~clk;
    assign imem_rdata = ~imem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc,
                          input logic [31:0] instr, input logic [31:0] idpc);
        chk({tag, ".pc"},    imem_addr,      pc);
        chk({tag, ".instr"}, ID_instruction, instr);
        chk({tag, ".idpc"},  ID_PC,          idpc);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; PCSrc = 3'd0; branch_taken = 1'b0;
        ConBA = '0; JT = '0; jr_target = '0;
        #3;
        chk_if("reset", 32'h8000_0000, 32'h0, 32'h8000_0004);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("seq_noflush", {31'd0, IF_flush}, 32'd0);
        step(); chk_if("fetch0", 32'h8000_0004, 32'h7FFF_FFFF, 32'h8000_0004);
        step(); chk_if("fetch1", 32'h8000_0008, 32'h7FFF_FFFB, 32'h8000_0008);

        // sequential wrap in user and kernel halves
        PCSrc = 3'd3; jr_target = 32'h7FFF_FFFC; #1;
        chk("jr_flush", {31'd0, IF_flush}, 32'd1);
        step(); chk_if("jr_7ffc", 32'h7FFF_FFFC, 32'h0, 32'h0000_0000);
        PCSrc = 3'd0;
        step(); chk_if("wrap_user", 32'h0000_0000, 32'h8000_0003, 32'h0000_0000);
        PCSrc = 3'd3; jr_target = 32'hFFFF_FFFF;
        step(); chk("jr_fffc", imem_addr, 32'hFFFF_FFFC);
        PCSrc = 3'd0;
        step(); chk_if("wrap_kern", 32'h8000_0000, 32'h0000_0003, 32'h8000_0000);

        // branch taken / not taken
        PCSrc = 3'd1; branch_taken = 1'b1; ConBA = 32'h0040_0040;
        step(); chk_if("br_taken", 32'h0040_0040, 32'h0, 32'h0040_0044);
        branch_taken = 1'b0; #1;
        chk("br_nt_noflush", {31'd0, IF_flush}, 32'd0);
        step(); chk_if("br_nt", 32'h0040_0044, 32'hFFBF_FFBF, 32'h0040_0044);

        // j uses ID_PC[31:28]
        PCSrc = 3'd3; jr_target = 32'h0040_0004;
        step(); chk("pre_j_idpc", ID_PC, 32'h0040_0008);
        PCSrc = 3'd2; JT = 26'h0000100;
        step(); chk_if("jump", 32'h0000_0400, 32'h0, 32'h0000_0404);

        // interrupt vector, then jr leaving kernel mode
        PCSrc = 3'd4;
        step(); chk_if("illop", 32'h8000_0004, 32'h0, 32'h8000_0008);
        PCSrc = 3'd3; jr_target = 32'h0040_0013;
        step(); chk_if("jr_user", 32'h0040_0010, 32'h0, 32'h0040_0014);
        PCSrc = 3'd5;
        step(); chk_if("xadr", 32'h8000_0008, 32'h0, 32'h8000_000C);
        PCSrc = 3'd0;
        step(); chk_if("post_x", 32'h8000_000C, 32'h7FFF_FFF7, 32'h8000_000C);

        // stall blocks a pending jump for 3 cycles
        stall = 1'b1; PCSrc = 3'd2; JT = 26'h0000040; #1;
        chk("stall_noflush", {31'd0, IF_flush}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); chk_if("stall_hold", 32'h8000_000C, 32'h7FFF_FFF7, 32'h8000_000C);
        end
        stall = 1'b0;
        step(); chk_if("stall_rel_j", 32'h8000_0100, 32'h0, 32'h8000_0104);

        // exception request while stalled is held off
        stall = 1'b1; PCSrc = 3'd5; #1;
        chk("xadr_stall_noflush", {31'd0, IF_flush}, 32'd0);
        step(); chk_if("xadr_stall", 32'h8000_0100, 32'h0, 32'h8000_0104);

        // reserved code behaves as sequential
        stall = 1'b0; PCSrc = 3'd6;
        step(); chk_if("rsvd6", 32'h8000_0104, 32'h7FFF_FEFF, 32'h8000_0104);

        // asynchronous reset mid-run, no clock edge
        PCSrc = 3'd0;
        reset = 1'b1; #1;
        chk_if("async_rst", 32'h8000_0000, 32'h0, 32'h8000_0004);
        step();
        @(negedge clk);
        reset = 1'b0;
        step(); chk_if("rst_rel", 32'h8000_0004, 32'h7FFF_FFFF, 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
